audio_gain_sequencer: RTL and testbench

- Time-multiplexes one log-volume ROM port and one 16x16 multiplier across the left and right channels.
- For each 48 kHz audio sample it forms the volume ROM address from the button volume, the USB volume and a soft-mute attenuation ramp.
- It then scales the magnitude of each channel, restores the sign, and hands a signed 32-bit pair to the noise shapers.
- It replaces the per-channel ROM/multiplier instances and the hard mute with a sequenced, click-free mute ramp.

---
 rtl/audio_gain_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_audio_gain_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_gain_sequencer.sv
// Audio gain sequencer.
//
// Shares one log-volume ROM port and one 16x16 multiplier between the left and
// right channels. For every accepted sample it issues the left ROM address, waits
// ROM_LATENCY cycles, multiplies, then does the same for the right channel. It
// then restores the signs and presents a signed 32-bit pair. A soft-mute
// attenuation register (att_q) ramps toward 255 while muted and toward 0
// otherwise, so mute/unmute is click-free.
//
// Ports:
//   clk_i              system clock
//   reset_i            synchronous, active-high reset
//   sample_ena_i       one-cycle strobe: new sample on audio_l_i/audio_r_i
//   audio_l_i/_r_i     signed 16-bit input samples
//   volume_usb_l_i/_r_i  USB host volume per channel
//   volume_buttons_i   local button volume, shared by both channels
//   mute_i             USB mute request
//   rom_address_o      registered volume ROM address (9 bit)
//   rom_data_i         unsigned ROM gain, valid ROM_LATENCY cycles after address
//   out_l_o/out_r_o    signed 32-bit scaled samples, held between strobes
//   out_valid_o        one-cycle strobe: outputs updated
//   busy_o             high while a sample is in flight
//   muted_o            mute_i high and attenuation saturated at 255
//   overrun_o          sticky: a sample strobe arrived while busy
module audio_gain_sequencer #(
  parameter int unsigned ROM_LATENCY = 1,  // 1..4
  parameter int unsigned RAMP_STEP   = 1   // 1..255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sample_ena_i,
  input  logic [15:0] audio_l_i,
  input  logic [15:0] audio_r_i,
  input  logic [7:0]  volume_usb_l_i,
  input  logic [7:0]  volume_usb_r_i,
  input  logic [7:0]  volume_buttons_i,
  input  logic        mute_i,
  output logic [8:0]  rom_address_o,
  input  logic [15:0] rom_data_i,
  output logic [31:0] out_l_o,
  output logic [31:0] out_r_o,
  output logic        out_valid_o,
  output logic        busy_o,
  output logic        muted_o,
  output logic        overrun_o
);

  localparam logic [2:0] CntLoad = 3'(ROM_LATENCY);
  localparam logic [7:0] Step    = 8'(RAMP_STEP);

  typedef enum logic [1:0] {StIdle, StWaitL, StWaitR, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_l_q, sign_l_d, sign_r_q, sign_r_d;
  logic [15:0] abs_l_q, abs_l_d, abs_r_q, abs_r_d;
  logic [31:0] prod_l_q, prod_l_d, prod_r_q, prod_r_d;
  logic [8:0]  rom_addr_q, rom_addr_d;
  logic [31:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  att_q, att_d;
  logic        overrun_q, overrun_d;
  logic        muted;

  // ROM address: buttons + usb + 1 minus attenuation, saturating at 0.
  function automatic logic [8:0] vol_addr(logic [7:0] btn, logic [7:0] usb, logic [7:0] att);
    logic [8:0] sum;
    sum = {1'b0, btn} + {1'b0, usb} + 9'd1;
    return (sum > {1'b0, att}) ? (sum - {1'b0, att}) : 9'd0;
  endfunction

  // Magnitude as unsigned, so 16'h8000 maps to 32768.
  function automatic logic [15:0] mag(logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  function automatic logic [31:0] mul(logic [15:0] a, logic [15:0] b);
    return {16'd0, a} * {16'd0, b};
  endfunction

  function automatic logic [31:0] apply_sign(logic s, logic [31:0] p);
    return s ? (~p + 32'd1) : p;
  endfunction

  assign muted = mute_i && (att_q == 8'hFF);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_l_d    = sign_l_q;
    sign_r_d    = sign_r_q;
    abs_l_d     = abs_l_q;
    abs_r_d     = abs_r_q;
    prod_l_d    = prod_l_q;
    prod_r_d    = prod_r_q;
    rom_addr_d  = rom_addr_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_valid_d = 1'b0;
    att_d       = att_q;
    // Strobes outside idle (including the done cycle) are dropped and flagged.
    overrun_d   = overrun_q | (sample_ena_i && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (sample_ena_i) begin
          sign_l_d   = audio_l_i[15];
          sign_r_d   = audio_r_i[15];
          abs_l_d    = mag(audio_l_i);
          abs_r_d    = mag(audio_r_i);
          rom_addr_d = vol_addr(volume_buttons_i, volume_usb_l_i, att_q);
          cnt_d      = CntLoad;
          state_d    = StWaitL;
        end
      end
      StWaitL: begin
        if (cnt_q == 3'd0) begin
          prod_l_d   = mul(abs_l_q, rom_data_i);
          rom_addr_d = vol_addr(volume_buttons_i, volume_usb_r_i, att_q);
          cnt_d      = CntLoad;
          state_d    = StWaitR;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StWaitR: begin
        if (cnt_q == 3'd0) begin
          prod_r_d = mul(abs_r_q, rom_data_i);
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        out_l_d     = muted ? 32'd0 : apply_sign(sign_l_q, prod_l_q);
        out_r_d     = muted ? 32'd0 : apply_sign(sign_r_q, prod_r_q);
        out_valid_d = 1'b1;
        if (mute_i) begin
          att_d = ({1'b0, att_q} + {1'b0, Step} > 9'd255) ? 8'hFF : (att_q + Step);
        end else begin
          att_d = (att_q < Step) ? 8'd0 : (att_q - Step);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      sign_l_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      abs_l_q     <= 16'd0;
      abs_r_q     <= 16'd0;
      prod_l_q    <= 32'd0;
      prod_r_q    <= 32'd0;
      rom_addr_q  <= 9'd0;
      out_l_q     <= 32'd0;
      out_r_q     <= 32'd0;
      out_valid_q <= 1'b0;
      att_q       <= 8'hFF;  // fade in after power-up
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_l_q    <= sign_l_d;
      sign_r_q    <= sign_r_d;
      abs_l_q     <= abs_l_d;
      abs_r_q     <= abs_r_d;
      prod_l_q    <= prod_l_d;
      prod_r_q    <= prod_r_d;
      rom_addr_q  <= rom_addr_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      att_q       <= att_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rom_address_o = rom_addr_q;
  assign out_l_o       = out_l_q;
  assign out_r_o       = out_r_q;
  assign out_valid_o   = out_valid_q;
  assign busy_o        = (state_q != StIdle);
  assign muted_o       = muted;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_audio_gain_sequencer.sv
// Bench for audio_gain_sequencer. Three instances share the stimulus:
//   0: ROM_LATENCY=1, RAMP_STEP=255   1: ROM_LATENCY=1, RAMP_STEP=1
//   2: ROM_LATENCY=3, RAMP_STEP=255
// A timeline model (offsets from the accepting edge) predicts every output and is
// compared each cycle; directed literal checks pin the model.
module tb_audio_gain_sequencer;

  logic        clk;
  logic        reset;
  logic        sample_ena;
  logic [15:0] audio_l, audio_r;
  logic [7:0]  usb_l, usb_r, buttons;
  logic        mute;
  logic        force_ffff;

  logic [8:0]  rom_addr [3];
  logic [15:0] rom_data [3];
  logic [31:0] out_l [3];
  logic [31:0] out_r [3];
  logic        valid [3];
  logic        busy [3];
  logic        muted [3];
  logic        ovr [3];

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic int step_of(int i);
    return (i == 1) ? 1 : 255;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LatG  = (g == 2) ? 3 : 1;
    localparam int unsigned StepG = (g == 1) ? 1 : 255;
    logic [8:0] pipe [4];

    audio_gain_sequencer #(
      .ROM_LATENCY(LatG),
      .RAMP_STEP  (StepG)
    ) u_dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .sample_ena_i    (sample_ena),
      .audio_l_i       (audio_l),
      .audio_r_i       (audio_r),
      .volume_usb_l_i  (usb_l),
      .volume_usb_r_i  (usb_r),
      .volume_buttons_i(buttons),
      .mute_i          (mute),
      .rom_address_o   (rom_addr[g]),
      .rom_data_i      (rom_data[g]),
      .out_l_o         (out_l[g]),
      .out_r_o         (out_r[g]),
      .out_valid_o     (valid[g]),
      .busy_o          (busy[g]),
      .muted_o         (muted[g]),
      .overrun_o       (ovr[g])
    );

    // ROM: data = address * 128, LatG cycles after the address changes.
    always @(posedge clk) begin
      pipe[0] <= rom_addr[g];
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end
    assign rom_data[g] = force_ffff ? 16'hFFFF : {pipe[LatG-1], 7'd0};
  end

  // ---------------- behavioural model ----------------
  int          m_att [3];
  bit          m_act [3];
  int          m_k [3];
  bit          m_sl [3], m_sr [3];
  longint      m_al [3], m_ar [3], m_pl [3], m_pr [3];
  int          m_addr [3];
  logic [31:0] m_out_l [3], m_out_r [3];
  bit          m_valid [3], m_ovr [3];

  function automatic int vaddr(int usb, int a);
    int s;
    s = int'(buttons) + usb + 1;
    return (s > a) ? s - a : 0;
  endfunction

  function automatic longint gain(int a);
    return force_ffff ? 64'd65535 : longint'(a) * 128;
  endfunction

  function automatic longint mag(logic [15:0] x);
    return x[15] ? 65536 - longint'(x) : longint'(x);
  endfunction

  function automatic logic [31:0] signed_out(bit s, longint p);
    longint v;
    v = s ? -p : p;
    return v[31:0];
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_att[i] = 255; m_act[i] = 0; m_k[i] = 0; m_addr[i] = 0;
      m_out_l[i] = 0; m_out_r[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int  lat;
      bit  mt;
      lat = lat_of(i);
      m_valid[i] = 0;
      if (reset) begin
        m_att[i] = 255; m_act[i] = 0; m_addr[i] = 0;
        m_out_l[i] = 0; m_out_r[i] = 0; m_ovr[i] = 0;
      end else if (m_act[i]) begin
        m_k[i]++;
        if (sample_ena) m_ovr[i] = 1;
        if (m_k[i] == lat + 1) begin
          m_pl[i]   = m_al[i] * gain(m_addr[i]);
          m_addr[i] = vaddr(int'(usb_r), m_att[i]);
        end else if (m_k[i] == 2 * lat + 2) begin
          m_pr[i] = m_ar[i] * gain(m_addr[i]);
        end else if (m_k[i] == 2 * lat + 3) begin
          mt = mute && (m_att[i] == 255);
          m_out_l[i] = mt ? 32'd0 : signed_out(m_sl[i], m_pl[i]);
          m_out_r[i] = mt ? 32'd0 : signed_out(m_sr[i], m_pr[i]);
          m_valid[i] = 1;
          if (mute) m_att[i] = (m_att[i] + step_of(i) > 255) ? 255 : m_att[i] + step_of(i);
          else      m_att[i] = (m_att[i] < step_of(i)) ? 0 : m_att[i] - step_of(i);
          m_act[i] = 0;
        end
      end else if (sample_ena) begin
        m_act[i]  = 1;
        m_k[i]    = 0;
        m_sl[i]   = audio_l[15];
        m_sr[i]   = audio_r[15];
        m_al[i]   = mag(audio_l);
        m_ar[i]   = mag(audio_r);
        m_addr[i] = vaddr(int'(usb_l), m_att[i]);
      end
    end
  end

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("addr", i, 32'(rom_addr[i]), 32'(m_addr[i]));
        chk("out_l", i, out_l[i], m_out_l[i]);
        chk("out_r", i, out_r[i], m_out_r[i]);
        chk("valid", i, 32'(valid[i]), 32'(m_valid[i]));
        chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
        chk("overrun", i, 32'(ovr[i]), 32'(m_ovr[i]));
        chk("muted", i, 32'(muted[i]), 32'(mute && (m_att[i] == 255)));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    chk(name, -1, act, exp);
  endtask

  // Accept a sample on the next edge, then let every instance drain.
  task automatic send_idle(logic [15:0] l, logic [15:0] r);
    audio_l = l; audio_r = r; sample_ena = 1'b1;
    step();
    sample_ena = 1'b0;
    repeat (11) step();
  endtask

  initial begin
    reset = 1'b1; sample_ena = 1'b0; audio_l = '0; audio_r = '0;
    usb_l = '0; usb_r = '0; buttons = '0; mute = 1'b0; force_ffff = 1'b0;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    lit("rst_addr", 32'(rom_addr[0]), 0);
    lit("rst_out_l", out_l[0], 0);
    lit("rst_valid", 32'(valid[0]), 0);
    lit("rst_busy", 32'(busy[0]), 0);
    lit("rst_overrun", 32'(ovr[0]), 0);
    mute = 1'b1; #1;
    lit("rst_muted", 32'(muted[0]), 1);
    mute = 1'b0; #1;
    reset = 1'b0;
    step();

    // Sample A: sum = 1, att = 255 -> address saturates to 0; latency per instance.
    audio_l = 16'd1000; audio_r = 16'hFC18; sample_ena = 1'b1;
    step();
    sample_ena = 1'b0;
    lit("sat_addr_L3", 32'(rom_addr[2]), 0);
    for (int n = 1; n <= 12; n++) begin
      step();
      lit("lat1_valid", 32'(valid[0]), 32'(n == 5));
      lit("lat3_valid", 32'(valid[2]), 32'(n == 9));
      if (n == 5) lit("sat_addr_R1", 32'(rom_addr[0]), 0);
    end

    // Sample B: sum 256, att now 0 on instance 0.
    buttons = 8'h7F; usb_l = 8'h80; usb_r = 8'h80;
    audio_l = 16'd1000; audio_r = 16'hFC18; sample_ena = 1'b1;
    step();
    sample_ena = 1'b0;
    lit("B_addrL", 32'(rom_addr[0]), 256);
    repeat (2) step();
    lit("B_addrR", 32'(rom_addr[0]), 256);
    repeat (3) step();
    lit("B_valid", 32'(valid[0]), 1);
    lit("B_outL", out_l[0], 32'd32768000);
    lit("B_outR", out_r[0], 32'hFE0C0000);
    repeat (7) step();

    // Full-scale negative input with maximum gain.
    force_ffff = 1'b1;
    audio_l = 16'h8000; audio_r = 16'h7FFF; sample_ena = 1'b1;
    step();
    sample_ena = 1'b0;
    repeat (5) step();
    lit("max_outL", out_l[0], 32'h80008000);
    lit("max_outR", out_r[0], 32'h7FFE8001);
    repeat (7) step();
    force_ffff = 1'b0;

    // Overrun: pulses at edges 0, 3 and 6.
    audio_l = 16'd77; audio_r = 16'd5; sample_ena = 1'b1;
    step();                 // edge 0
    sample_ena = 1'b0;
    lit("ovr_before", 32'(ovr[0]), 0);
    repeat (2) step();      // edge 2
    sample_ena = 1'b1;
    step();                 // edge 3
    sample_ena = 1'b0;
    lit("ovr_set", 32'(ovr[0]), 1);
    repeat (2) step();      // edge 5
    lit("ovr_valid1", 32'(valid[0]), 1);
    sample_ena = 1'b1;
    step();                 // edge 6
    sample_ena = 1'b0;
    lit("ovr_accept", 32'(busy[0]), 1);
    repeat (5) step();      // edge 11
    lit("ovr_valid2", 32'(valid[0]), 1);
    repeat (12) step();
    lit("ovr_sticky", 32'(ovr[0]), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    lit("ovr_cleared", 32'(ovr[0]), 0);

    // Ramp on instance 1: fade in, mute ramp, unmute ramp.
    buttons = 8'h00; usb_l = 8'hFF; usb_r = 8'hFF;
    for (int j = 0; j < 255; j++) send_idle(16'd1000, 16'hFC18);
    lit("ramp_unmuted", 32'(muted[1]), 0);
    mute = 1'b1;
    for (int j = 1; j <= 255; j++) begin
      audio_l = 16'd1000; audio_r = 16'hFC18; sample_ena = 1'b1;
      step();
      sample_ena = 1'b0;
      if (j <= 3 || j == 255) lit("ramp_addr", 32'(rom_addr[1]), 32'(257 - j));
      repeat (11) step();
    end
    lit("ramp_muted", 32'(muted[1]), 1);
    audio_l = 16'd1000; audio_r = 16'hFC18; sample_ena = 1'b1;
    step();
    sample_ena = 1'b0;
    repeat (5) step();
    lit("ramp_out_zero", out_l[1], 0);
    repeat (6) step();
    mute = 1'b0;
    for (int j = 0; j < 255; j++) send_idle(16'd1000, 16'hFC18);
    audio_l = 16'd1000; audio_r = 16'hFC18; sample_ena = 1'b1;
    step();
    sample_ena = 1'b0;
    lit("ramp_back_addr", 32'(rom_addr[1]), 256);
    repeat (5) step();
    lit("ramp_back_out", out_l[1], 32'd32768000);
    repeat (6) step();

    // Reset while instance 0 is in WAIT_R.
    audio_l = 16'd123; audio_r = 16'd456; sample_ena = 1'b1;
    step();                 // edge 0
    sample_ena = 1'b0;
    repeat (2) step();      // edge 2: waiting on right channel
    reset = 1'b1;
    step();
    reset = 1'b0;
    lit("mid_rst_busy", 32'(busy[0]), 0);
    lit("mid_rst_out", out_l[0], 0);
    lit("mid_rst_addr", 32'(rom_addr[0]), 0);
    for (int n = 0; n < 8; n++) begin
      lit("mid_rst_novalid", 32'(valid[0]), 0);
      step();
    end
    mute = 1'b1; #1;
    lit("mid_rst_att", 32'(muted[0]), 1);
    mute = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
